rt_block_writer: RTL

RT_BLOCK_WRITER -- requirements
Module: rt_block_writer

---
 rtl/rt_block_writer_pkg.sv | 39 +++
 rtl/rt_block_writer_if.sv | 29 ++
 rtl/rt_quad_buffer.sv | 40 ++++
 rtl/rt_block_writer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/rt_block_writer_pkg.sv
// rt_block_writer_pkg: shared register map, write-out state encoding and helpers.
// Revision 1.0
`default_nettype none
package rt_block_writer_pkg;

  localparam logic [7:0] ADDR_BOARD_STATUS = 8'h00;
  localparam logic [3:0] REG_DAC_CURRENT   = 4'd1;

  localparam logic [3:0] DAC_OFF_DEFAULT   = REG_DAC_CURRENT;
  localparam logic [7:0] STAT_ADDR_DEFAULT = ADDR_BOARD_STATUS;

  localparam int QB_DEPTH = 16;
  localparam int QB_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_START   = 3'd1,
    ST_SETUP   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_NEXT    = 3'd4,
    ST_BLKEND  = 3'd5,
    ST_DONE    = 3'd6
  } bw_state_t;

  // Bits 0..n set: header plus every data entry of an n-quadlet packet.
  function automatic logic [15:0] valid_mask(input logic [3:0] n);
    logic [16:0] m;
    m = (17'd1 << ({1'b0, n} + 5'd1)) - 17'd1;
    return m[15:0];
  endfunction

  function automatic logic [7:0] entry_addr(input logic [3:0] k, input logic [3:0] n,
                                            input logic [3:0] dac_off,
                                            input logic [7:0] stat_addr);
    return (k == n) ? stat_addr : {k - 4'd1, dac_off};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rt_block_writer_if.sv
// rt_block_writer_if: real-time quadlet input plus register/block write bus.
// Revision 1.0
`default_nettype none
interface rt_block_writer_if;
  logic        rt_wen;
  logic [3:0]  rt_waddr;
  logic [31:0] rt_wdata;
  logic        bw_write_en;
  logic [7:0]  bw_reg_waddr;
  logic [31:0] bw_reg_wdata;
  logic        bw_reg_wen;
  logic        bw_blk_wstart;
  logic        bw_blk_wen;
  logic        rt_done;
  logic [7:0]  rt_ovr_cnt;

  modport master (
    input  rt_wen, rt_waddr, rt_wdata,
    output bw_write_en, bw_reg_waddr, bw_reg_wdata, bw_reg_wen,
           bw_blk_wstart, bw_blk_wen, rt_done, rt_ovr_cnt
  );

  modport slave (
    output rt_wen, rt_waddr, rt_wdata,
    input  bw_write_en, bw_reg_waddr, bw_reg_wdata, bw_reg_wen,
           bw_blk_wstart, bw_blk_wen, rt_done, rt_ovr_cnt
  );
endinterface
`default_nettype wire

// File: rtl/rt_quad_buffer.sv
// rt_quad_buffer: 16x32 quadlet store with valid bitmap, 1W/1R, combinational read.
// Revision 1.0
`default_nettype none
module rt_quad_buffer
  import rt_block_writer_pkg::*;
(
  input  wire logic                clk,
  input  wire logic                rstn,
  input  wire logic                clr_i,
  input  wire logic                we_i,
  input  wire logic [3:0]          waddr_i,
  input  wire logic [QB_WIDTH-1:0] wdata_i,
  input  wire logic [3:0]          raddr_i,
  output logic      [QB_WIDTH-1:0] rdata_o,
  output logic      [QB_DEPTH-1:0] valid_o
);

  logic [QB_WIDTH-1:0] mem_q [QB_DEPTH];
  logic [QB_DEPTH-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // A clear together with a write leaves only the written entry valid (header store).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
    end else if (clr_i) begin
      valid_q <= we_i ? (16'd1 << waddr_i) : '0;
    end else if (we_i) begin
      valid_q[waddr_i] <= 1'b1;
    end
  end

  assign rdata_o = mem_q[raddr_i];
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/rt_block_writer.sv
// rt_block_writer: collects a real-time packet and writes it out as one register block.
// Revision 1.0
`default_nettype none
module rt_block_writer
  import rt_block_writer_pkg::*;
#(
  parameter logic [3:0] DAC_OFF   = DAC_OFF_DEFAULT,
  parameter logic [7:0] STAT_ADDR = STAT_ADDR_DEFAULT
) (
  input wire logic            sysclk,
  input wire logic            rstn,
  rt_block_writer_if.master   bus
);

  bw_state_t   state_q;
  logic [3:0]  n_q, idx_q, rd_idx;
  logic [7:0]  ovr_q, ovr_d;
  logic        write_en_q, reg_wen_q, blk_wstart_q, blk_wen_q, done_q;
  logic [7:0]  reg_waddr_q;
  logic [31:0] reg_wdata_q, rdata;
  logic [15:0] valid;
  logic        complete, accept, is_hdr, hdr_ok, data_ok, drop, buf_we, buf_clr;

  assign complete = (n_q >= 4'd2) && ((valid & valid_mask(n_q)) == valid_mask(n_q));
  assign accept   = (state_q == ST_COLLECT) && !complete;
  assign is_hdr   = (bus.rt_waddr == 4'd0);
  assign hdr_ok   = bus.rt_wen && accept && is_hdr && (bus.rt_wdata[3:0] >= 4'd2);
  assign data_ok  = bus.rt_wen && accept && !is_hdr && (n_q != 4'd0) && (bus.rt_waddr <= n_q);
  assign drop     = bus.rt_wen && !hdr_ok && !data_ok;
  assign buf_we   = hdr_ok || data_ok;
  assign buf_clr  = (bus.rt_wen && accept && is_hdr) || (state_q == ST_DONE);
  assign ovr_d    = (drop && (ovr_q != 8'hFF)) ? ovr_q + 8'd1 : ovr_q;
  assign rd_idx   = (state_q == ST_NEXT) ? idx_q + 4'd1 : idx_q;

  rt_quad_buffer u_buf (
    .clk     (sysclk),
    .rstn    (rstn),
    .clr_i   (buf_clr),
    .we_i    (buf_we),
    .waddr_i (bus.rt_waddr),
    .wdata_i (bus.rt_wdata),
    .raddr_i (rd_idx),
    .rdata_o (rdata),
    .valid_o (valid)
  );

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_COLLECT;
      n_q          <= '0;
      idx_q        <= '0;
      ovr_q        <= '0;
      write_en_q   <= 1'b0;
      reg_wen_q    <= 1'b0;
      blk_wstart_q <= 1'b0;
      blk_wen_q    <= 1'b0;
      done_q       <= 1'b0;
      reg_waddr_q  <= '0;
      reg_wdata_q  <= '0;
    end else begin
      ovr_q        <= ovr_d;
      reg_wen_q    <= 1'b0;
      blk_wstart_q <= 1'b0;
      blk_wen_q    <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        ST_COLLECT: begin
          if (hdr_ok) n_q <= bus.rt_wdata[3:0];
          else if (bus.rt_wen && accept && is_hdr) n_q <= '0;
          if (complete) begin
            state_q      <= ST_START;
            write_en_q   <= 1'b1;
            blk_wstart_q <= 1'b1;
            idx_q        <= 4'd1;
          end
        end
        ST_START: begin
          state_q     <= ST_SETUP;
          reg_waddr_q <= entry_addr(rd_idx, n_q, DAC_OFF, STAT_ADDR);
          reg_wdata_q <= rdata;
        end
        ST_SETUP: begin
          state_q   <= ST_WRITE;
          reg_wen_q <= 1'b1;
        end
        ST_WRITE: state_q <= ST_NEXT;
        ST_NEXT: begin
          if (idx_q == n_q) begin
            state_q     <= ST_BLKEND;
            blk_wen_q   <= 1'b1;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
          end else begin
            state_q     <= ST_SETUP;
            idx_q       <= rd_idx;
            reg_waddr_q <= entry_addr(rd_idx, n_q, DAC_OFF, STAT_ADDR);
            reg_wdata_q <= rdata;
          end
        end
        ST_BLKEND: begin
          state_q    <= ST_DONE;
          write_en_q <= 1'b0;
          done_q     <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_COLLECT;
          n_q     <= '0;
          idx_q   <= '0;
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

  assign bus.bw_write_en   = write_en_q;
  assign bus.bw_reg_waddr  = reg_waddr_q;
  assign bus.bw_reg_wdata  = reg_wdata_q;
  assign bus.bw_reg_wen    = reg_wen_q;
  assign bus.bw_blk_wstart = blk_wstart_q;
  assign bus.bw_blk_wen    = blk_wen_q;
  assign bus.rt_done       = done_q;
  assign bus.rt_ovr_cnt    = ovr_q;

endmodule
`default_nettype wire
